// File: rtl/id_stage_sb.sv
// id_stage_sb: decode stage with banked register file, write scoreboard
// and a valid/ready ID/EXE output register.
module id_stage_sb #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int NBANK = 2,
   localparam int AW = $clog2(NREG),
   localparam int BW = (NBANK > 1) ? $clog2(NBANK) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_pc,
   input  logic [31:0]     in_instr,
   input  logic [BW-1:0]   in_rs1_bank,
   input  logic [BW-1:0]   in_rs2_bank,
   input  logic [BW-1:0]   in_rd_bank,
   input  logic            in_rd_we,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [31:0]     out_instr,
   output logic [XLEN-1:0] out_rs1_data,
   output logic [XLEN-1:0] out_rs2_data,
   output logic [BW-1:0]   out_rd_bank,
   output logic            out_rd_we,
   input  logic            wb_valid,
   input  logic            wb_kill,
   input  logic [BW-1:0]   wb_bank,
   input  logic [AW-1:0]   wb_addr,
   input  logic [XLEN-1:0] wb_data
);
   localparam int IW = BW + AW;
   localparam int N = 1 << IW;

   logic [XLEN-1:0] rf_q [N];
   logic [XLEN-1:0] rf_d [N];
   logic [N-1:0]    pend_q, pend_d;
   logic            out_valid_q, out_valid_d;
   logic [XLEN-1:0] out_pc_q, out_pc_d;
   logic [31:0]     out_instr_q, out_instr_d;
   logic [XLEN-1:0] out_rs1_q, out_rs1_d;
   logic [XLEN-1:0] out_rs2_q, out_rs2_d;
   logic [BW-1:0]   out_rd_bank_q, out_rd_bank_d;
   logic            out_rd_we_q, out_rd_we_d;
   logic [IW-1:0]   rs1_idx, rs2_idx, rd_idx, wb_idx, kill_idx;
   logic [XLEN-1:0] rs1_data, rs2_data;
   logic            wr_en, hazard, accept;

   // Index 0 is bank 0 register 0: never written, always reads zero.
   always_comb begin
      rs1_idx = {in_rs1_bank, in_instr[15 +: AW]};
      rs2_idx = {in_rs2_bank, in_instr[20 +: AW]};
      rd_idx = {in_rd_bank, in_instr[7 +: AW]};
      wb_idx = {wb_bank, wb_addr};
      kill_idx = {out_rd_bank_q, out_instr_q[7 +: AW]};
      wr_en = wb_valid & ~wb_kill & (wb_idx != '0);
      rs1_data = (rs1_idx == '0) ? '0 : (wr_en && wb_idx == rs1_idx) ? wb_data : rf_q[rs1_idx];
      rs2_data = (rs2_idx == '0) ? '0 : (wr_en && wb_idx == rs2_idx) ? wb_data : rf_q[rs2_idx];
      hazard = (pend_q[rs1_idx] & ~(wb_valid && wb_idx == rs1_idx))
             | (pend_q[rs2_idx] & ~(wb_valid && wb_idx == rs2_idx))
             | (in_rd_we & pend_q[rd_idx] & ~(wb_valid && wb_idx == rd_idx));
      in_ready = rst & ~hazard & ~flush & (~out_valid_q | out_ready);
      accept = in_valid & in_ready;
      rf_d = rf_q;
      if (wr_en) rf_d[wb_idx] = wb_data;
      // Ordering gives flush-clear < wb-clear < accept-set priority.
      pend_d = pend_q;
      if (flush & out_valid_q & ~out_ready & out_rd_we_q) pend_d[kill_idx] = 1'b0;
      if (wb_valid) pend_d[wb_idx] = 1'b0;
      if (accept & in_rd_we & (rd_idx != '0)) pend_d[rd_idx] = 1'b1;
      out_valid_d = flush ? 1'b0 : accept ? 1'b1 : out_valid_q & ~out_ready;
      out_pc_d = accept ? in_pc : out_pc_q;
      out_instr_d = accept ? in_instr : out_instr_q;
      out_rs1_d = accept ? rs1_data : out_rs1_q;
      out_rs2_d = accept ? rs2_data : out_rs2_q;
      out_rd_bank_d = accept ? in_rd_bank : out_rd_bank_q;
      out_rd_we_d = accept ? in_rd_we : out_rd_we_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < N; i++) rf_q[i] <= '0;
         pend_q <= '0;
         out_valid_q <= 1'b0;
         out_pc_q <= '0;
         out_instr_q <= '0;
         out_rs1_q <= '0;
         out_rs2_q <= '0;
         out_rd_bank_q <= '0;
         out_rd_we_q <= 1'b0;
      end else begin
         rf_q <= rf_d;
         pend_q <= pend_d;
         out_valid_q <= out_valid_d;
         out_pc_q <= out_pc_d;
         out_instr_q <= out_instr_d;
         out_rs1_q <= out_rs1_d;
         out_rs2_q <= out_rs2_d;
         out_rd_bank_q <= out_rd_bank_d;
         out_rd_we_q <= out_rd_we_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_pc = out_pc_q;
   assign out_instr = out_instr_q;
   assign out_rs1_data = out_rs1_q;
   assign out_rs2_data = out_rs2_q;
   assign out_rd_bank = out_rd_bank_q;
   assign out_rd_we = out_rd_we_q;
endmodule

// File: tb/tb_id_stage_sb.sv
// tb_id_stage_sb: scenario tasks for id_stage_sb; accepted instructions are
// queued with predicted operands and matched when EXE consumes the entry.
module tb_id_stage_sb;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_pc = '0;
   logic [31:0] in_instr = '0;
   logic        in_rs1_bank = 1'b0;
   logic        in_rs2_bank = 1'b0;
   logic        in_rd_bank = 1'b0;
   logic        in_rd_we = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic [31:0] out_rs1_data;
   logic [31:0] out_rs2_data;
   logic        out_rd_bank;
   logic        out_rd_we;
   logic        wb_valid = 1'b0;
   logic        wb_kill = 1'b0;
   logic        wb_bank = 1'b0;
   logic [4:0]  wb_addr = '0;
   logic [31:0] wb_data = '0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] r1;
      logic [31:0] r2;
      logic        bk;
      logic        we;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   logic [31:0] mrf [2][32];
   int          total = 0;
   int          bad = 0;

   localparam logic [31:0] ADDI5 = {12'h001, 5'd0, 3'b000, 5'd5, 7'h13};
   localparam logic [31:0] ADD655 = {7'h00, 5'd5, 5'd5, 3'b000, 5'd6, 7'h33};
   localparam logic [31:0] RD00 = {7'h00, 5'd0, 5'd0, 3'b000, 5'd1, 7'h33};
   localparam logic [31:0] IA = {7'h00, 5'd1, 5'd5, 3'b000, 5'd8, 7'h33};
   localparam logic [31:0] IB = {7'h00, 5'd5, 5'd0, 3'b000, 5'd8, 7'h33};
   localparam logic [31:0] IC = {7'h00, 5'd6, 5'd5, 3'b000, 5'd8, 7'h33};
   localparam logic [31:0] W7 = {12'h007, 5'd0, 3'b000, 5'd7, 7'h13};
   localparam logic [31:0] R7 = {7'h00, 5'd7, 5'd7, 3'b000, 5'd11, 7'h33};
   localparam logic [31:0] W9A = {12'h001, 5'd0, 3'b000, 5'd9, 7'h13};
   localparam logic [31:0] W9B = {12'h002, 5'd0, 3'b000, 5'd9, 7'h13};
   localparam logic [31:0] R9 = {7'h00, 5'd0, 5'd9, 3'b000, 5'd12, 7'h33};
   localparam logic [31:0] W10 = {12'h003, 5'd0, 3'b000, 5'd10, 7'h13};
   localparam logic [31:0] R510 = {7'h00, 5'd10, 5'd5, 3'b000, 5'd13, 7'h33};

   id_stage_sb dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
      .in_rs1_bank(in_rs1_bank), .in_rs2_bank(in_rs2_bank), .in_rd_bank(in_rd_bank),
      .in_rd_we(in_rd_we), .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_instr(out_instr), .out_rs1_data(out_rs1_data),
      .out_rs2_data(out_rs2_data), .out_rd_bank(out_rd_bank), .out_rd_we(out_rd_we),
      .wb_valid(wb_valid), .wb_kill(wb_kill), .wb_bank(wb_bank),
      .wb_addr(wb_addr), .wb_data(wb_data)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   // Reference register read: x0 of bank 0 is zero, a live writeback forwards.
   function automatic logic [31:0] mread(input logic b, input logic [4:0] a);
      if (b == 1'b0 && a == 5'd0) return 32'h0;
      if (wb_valid && !wb_kill && wb_bank == b && wb_addr == a) return wb_data;
      return mrf[b][a];
   endfunction

   // Consumer side: a handshake seen here completes at the next rising edge.
   always begin
      @(negedge clk);
      #2;
      if (rst && out_valid && out_ready) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL out_unexpected got pc=%h required none", out_pc);
         end else begin
            mon_e = sb.pop_front();
            if ({out_pc, out_instr, out_rs1_data, out_rs2_data, out_rd_bank, out_rd_we} !==
                {mon_e.pc, mon_e.instr, mon_e.r1, mon_e.r2, mon_e.bk, mon_e.we}) begin
               bad++;
               $display("FAIL out_entry got pc=%h instr=%h rs1=%h rs2=%h bk=%b we=%b required pc=%h instr=%h rs1=%h rs2=%h bk=%b we=%b",
                        out_pc, out_instr, out_rs1_data, out_rs2_data, out_rd_bank, out_rd_we,
                        mon_e.pc, mon_e.instr, mon_e.r1, mon_e.r2, mon_e.bk, mon_e.we);
            end
         end
      end
   end

   task automatic send(input logic [31:0] pc, input logic [31:0] instr, input logic b1,
                       input logic b2, input logic bd, input logic we, input int budget);
      in_valid = 1'b1; in_pc = pc; in_instr = instr;
      in_rs1_bank = b1; in_rs2_bank = b2; in_rd_bank = bd; in_rd_we = we;
      total++;
      for (int i = 0; i < budget; i++) begin
         #1;
         if (in_ready === 1'b1) begin
            sb.push_back('{pc, instr, mread(b1, instr[19:15]), mread(b2, instr[24:20]), bd, we});
            @(negedge clk);
            in_valid = 1'b0;
            return;
         end
         @(negedge clk);
      end
      bad++;
      $display("FAIL send_accept pc=%h got in_ready=0 required 1 within %0d cycles", pc, budget);
      in_valid = 1'b0;
   endtask

   task automatic wb_pulse(input logic b, input logic [4:0] a, input logic [31:0] d, input logic k);
      wb_valid = 1'b1; wb_bank = b; wb_addr = a; wb_data = d; wb_kill = k;
      @(negedge clk);
      if (!k && !(b == 1'b0 && a == 5'd0)) mrf[b][a] = d;
      wb_valid = 1'b0; wb_kill = 1'b0;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (sb.size() == 0 && out_valid === 1'b0) return;
      end
      total++; bad++;
      $display("FAIL drain got pending=%0d out_valid=%b required 0 0", sb.size(), out_valid);
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      total++;
      if ({out_valid, in_ready} !== 2'b00) begin
         bad++; $display("FAIL reset_flags got valid=%b ready=%b required 0 0", out_valid, in_ready);
      end
      total++;
      if ({out_pc, out_instr, out_rs1_data, out_rs2_data} !== 128'h0) begin
         bad++; $display("FAIL reset_data got pc=%h instr=%h required 0", out_pc, out_instr);
      end
      rst = 1'b1;
      #1;
      total++;
      if (in_ready !== 1'b1) begin
         bad++; $display("FAIL reset_release_ready got %b required 1", in_ready);
      end
      @(negedge clk);
   endtask

   task automatic test_raw();
      out_ready = 1'b1;
      send(32'h100, ADDI5, 0, 0, 0, 1, 3);
      in_valid = 1'b1; in_pc = 32'h104; in_instr = ADD655;
      in_rs1_bank = 0; in_rs2_bank = 0; in_rd_bank = 0; in_rd_we = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++;
         if (in_ready !== 1'b0) begin
            bad++; $display("FAIL raw_stall cycle %0d got in_ready=%b required 0", i, in_ready);
         end
         @(negedge clk);
      end
      wb_valid = 1'b1; wb_kill = 1'b0; wb_bank = 0; wb_addr = 5'd5; wb_data = 32'h1234;
      send(32'h104, ADD655, 0, 0, 0, 1, 1);
      wb_valid = 1'b0;
      mrf[0][5] = 32'h1234;
      wb_pulse(0, 5'd6, 32'h66, 0);
      drain();
   endtask

   task automatic test_x0_fp();
      wb_pulse(0, 5'd0, 32'hFFFF_FFFF, 0);
      wb_pulse(1, 5'd0, 32'hA5, 0);
      out_ready = 1'b1;
      send(32'h200, RD00, 0, 1, 0, 0, 2);
      send(32'h204, RD00, 1, 0, 0, 0, 2);
      drain();
   endtask

   task automatic test_stall();
      out_ready = 1'b0;
      send(32'h300, IA, 0, 0, 0, 0, 2);
      in_valid = 1'b1; in_pc = 32'h304; in_instr = IB;
      in_rs1_bank = 1; in_rs2_bank = 0; in_rd_bank = 0; in_rd_we = 0;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++;
         if ({out_valid, in_ready, out_pc, out_instr, out_rs1_data} !== {2'b10, 32'h300, IA, 32'h1234}) begin
            bad++;
            $display("FAIL stall_hold cycle %0d got valid=%b ready=%b pc=%h instr=%h rs1=%h required 1 0 %h %h %h",
                     i, out_valid, in_ready, out_pc, out_instr, out_rs1_data, 32'h300, IA, 32'h1234);
         end
         @(negedge clk);
      end
      out_ready = 1'b1;
      send(32'h304, IB, 1, 0, 0, 0, 1);
      total++;
      if ({out_valid, out_pc} !== {1'b1, 32'h304}) begin
         bad++; $display("FAIL stall_no_bubble got valid=%b pc=%h required 1 %h", out_valid, out_pc, 32'h304);
      end
      send(32'h308, IC, 0, 0, 1, 0, 1);
      drain();
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      send(32'h400, W7, 0, 0, 0, 1, 2);
      flush = 1'b1;
      void'(sb.pop_back());
      #1;
      total++;
      if (in_ready !== 1'b0) begin
         bad++; $display("FAIL flush_ready got %b required 0", in_ready);
      end
      @(negedge clk);
      flush = 1'b0;
      total++;
      if (out_valid !== 1'b0) begin
         bad++; $display("FAIL flush_valid got %b required 0", out_valid);
      end
      send(32'h404, R7, 0, 0, 0, 0, 1);
      drain();
   endtask

   task automatic test_set_win();
      out_ready = 1'b1;
      send(32'h500, W9A, 0, 0, 0, 1, 2);
      wb_valid = 1'b1; wb_kill = 1'b0; wb_bank = 0; wb_addr = 5'd9; wb_data = 32'h99;
      send(32'h504, W9B, 0, 0, 0, 1, 1);
      wb_valid = 1'b0;
      mrf[0][9] = 32'h99;
      in_valid = 1'b1; in_pc = 32'h508; in_instr = R9;
      in_rs1_bank = 0; in_rs2_bank = 0; in_rd_bank = 0; in_rd_we = 0;
      for (int i = 0; i < 2; i++) begin
         #1;
         total++;
         if (in_ready !== 1'b0) begin
            bad++; $display("FAIL setwin_pending cycle %0d got in_ready=%b required 0", i, in_ready);
         end
         @(negedge clk);
      end
      wb_valid = 1'b1; wb_kill = 1'b1; wb_bank = 0; wb_addr = 5'd9; wb_data = 32'hDEAD;
      send(32'h508, R9, 0, 0, 0, 0, 1);
      wb_valid = 1'b0; wb_kill = 1'b0;
      send(32'h50C, R9, 0, 0, 0, 0, 1);
      drain();
   endtask

   task automatic test_reset_stall();
      out_ready = 1'b0;
      send(32'h600, W10, 0, 0, 0, 1, 2);
      in_valid = 1'b1; in_pc = 32'h604; in_instr = R510;
      in_rs1_bank = 0; in_rs2_bank = 0; in_rd_bank = 0; in_rd_we = 0;
      #3;
      rst = 1'b0;
      #1;
      total++;
      if ({out_valid, in_ready, out_rd_we} !== 3'b000) begin
         bad++; $display("FAIL rst_async_flags got valid=%b ready=%b we=%b required 0 0 0", out_valid, in_ready, out_rd_we);
      end
      total++;
      if ({out_pc, out_instr, out_rs1_data} !== 96'h0) begin
         bad++; $display("FAIL rst_async_data got pc=%h instr=%h rs1=%h required 0", out_pc, out_instr, out_rs1_data);
      end
      in_valid = 1'b0;
      sb.delete();
      for (int b = 0; b < 2; b++) for (int r = 0; r < 32; r++) mrf[b][r] = 32'h0;
      @(negedge clk);
      rst = 1'b1;
      out_ready = 1'b1;
      send(32'h604, R510, 0, 0, 0, 0, 1);
      drain();
   endtask

   initial begin
      for (int b = 0; b < 2; b++) for (int r = 0; r < 32; r++) mrf[b][r] = 32'h0;
      test_reset();
      test_raw();
      test_x0_fp();
      test_stall();
      test_flush();
      test_set_win();
      test_reset_stall();
      total++;
      if (sb.size() != 0) begin
         bad++; $display("FAIL leftover_entries got %0d required 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
